lfsr_ext_counter: RTL
=====================

# lfsr_ext_counter

Parametrised high-speed counter built on a de Bruijn (state-extended) Fibonacci LFSR. It walks all 2^WIDTH states, including all-zero, so it needs no separate extension register chain. It adds:
- programmable terminal state, giving modulus 1..2^WIDTH;
- synchronous load;
- stop-at-terminal (one-shot) mode;
- combinational carry-out for zero-delay cascading of instances.

It is the general replacement for the fixed 3-bit LFSR counters and is used as the prescaler / event-counter primitive across the counter library.

## Interface
Parameters:
- WIDTH, 3, state width; legal range 3..16; out-of-range is an elaboration error.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- CNT  in  1  count enable; also the cascade input from the previous stage's Next.
- Load  in  1  synchronous load of D.
- D  in  WIDTH  load value (LFSR-domain state).
- Term  in  WIDTH  terminal state (LFSR-domain); sampled every cycle.
- Stop  in  1  0 = wrap mode, 1 = one-shot mode.
- Q  out  WIDTH  current state, registered.
- Next  out  1  carry-out: CNT & (Q == Term) & ~Rst & ~Load & ~Halt; combinational.
- Halt  out  1  registered; 1 while stopped at Term in one-shot mode.

## Operation
- Step function, shift toward the MSB:
  - Qn = {Q[WIDTH-2:0], fb}
  - fb = XOR of the tapped bits of Q, XORed with (Q[WIDTH-2:0] == 0)
  - The tap term always includes Q[WIDTH-1]. The zero-detect term inserts the all-zero state between 10…0 and 0…01.
- Sequence from reset, WIDTH=3 (taps 3,2): 000 → 001 → 010 → 101 → 011 → 111 → 110 → 100 → 000.
- Priority per rising Clk edge, first match wins:
  1. Rst: Q ← 0, Halt ← 0.
  2. Load: Q ← D, Halt ← 0.
  3. Halt = 1: hold. CNT is ignored and Next stays 0.
  4. CNT = 1 and Q == Term:
     - Stop = 0: Q ← 0. This wraps to the seed, so the modulus equals index(Term) + 1.
     - Stop = 1: Q holds, Halt ← 1.
  5. CNT = 1: Q ← step(Q).
  6. Otherwise: hold.
- Term = 10…0 (index 2^WIDTH−1) gives the full-length modulus 2^WIDTH. Term = 0 gives modulus 1: Q stays 0 and Next = CNT.
- Load of a value beyond Term in the sequence: the counter runs past Term, continues to 10…0, then the natural step takes it to 0…0. Any D is legal and no lock-up state exists.
- Changing Term mid-count takes effect on the same cycle's compare.
- Clearing Stop while Halt = 1 does not release Halt. Only Rst or Load releases it.

## Timing
- Reset values: Q = 0, Halt = 0, Next = 0.
- Q updates one cycle after the enabling edge. Load latency is 1 cycle.
- Next is combinational, with no register between CNT and Next. Chained instances (Next → CNT of the next stage) advance on the same edge, like a ripple-free synchronous carry.
- Critical path: the WIDTH-bit compare plus the AND chain through the cascade. The step path is at most 4 taps plus one zero-detect, and stays independent of WIDTH beyond the (WIDTH−1)-input NOR.
- Rst asserted mid-count or while halted forces Q = 0 on that edge. Next is 0 during the Rst cycle.

## Structure
- Shared package lfsr_pkg holds:
  - the tap table function taps(WIDTH), returning a 16-bit mask. Taps (1-based): 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1; 15:15,14; 16:16,15,13,4.
  - constants WIDTH_MIN = 3 and WIDTH_MAX = 16.
- Sub-module lfsr_ext_step is purely combinational, parametrised by WIDTH, and computes Qn from Q. It is reused by the bench reference model.

## Test plan
- WIDTH=3, Rst then CNT=1, Term=100, Stop=0 for 9 cycles:
  - Q steps 000,001,010,101,011,111,110,100,000.
  - Next is high only in the 100 cycle.
- WIDTH=3, Term=111, Stop=0: period is 6 (000→…→111→000), with one Next pulse per period.
- WIDTH=3, Term=011, Stop=1:
  - Q reaches 011, Halt rises the next cycle, and Q holds with Next = 0 under continuous CNT.
  - Load with D=000 resumes counting.
- Two cascaded WIDTH=4 instances, full modulus: after 256 CNT cycles both are back at 0000. The upper stage advances exactly once per 16 lower counts, on the same edge as the lower wrap.
- Simultaneous Rst, Load and CNT with D=101: Q = 000. Then Load+CNT with D=101 and Q == Term: Q = 101 and Next = 0.
- For WIDTH 3..16, run exhaustively from reset with Term = 10…0: all 2^WIDTH states are visited exactly once before returning to 0, checked against lfsr_ext_step.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and tap table for the state-extended Fibonacci LFSR counters.
// Tap masks are 1-based tap positions mapped onto bit (tap-1) of a 16-bit mask.
package lfsr_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 16;

  // Maximal-length tap sets; the MSB tap is always present so the zero-detect
  // term can splice the all-zero state into the sequence.
  function automatic logic [15:0] taps(input int width);
    logic [15:0] mask;
    mask = '0;
    case (width)
      3:       mask = 16'h0006;
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_ext_step.sv
// Combinational next-state function of the de Bruijn LFSR: shift toward the MSB,
// feedback from the tap XOR with the all-zero state inserted after 10...0.
module lfsr_ext_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(taps(WIDTH));

  logic fb;

  assign fb = (^(q & TAP_MASK)) ^ (q[WIDTH-2:0] == '0);
  assign qn = {q[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_ext_counter.sv
// Programmable-modulus LFSR counter with load, one-shot stop and a combinational
// carry-out that lets chained stages advance on the same clock edge.
module lfsr_ext_counter
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CNT,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Term,
  input  logic             Stop,
  output logic [WIDTH-1:0] Q,
  output logic             Next,
  output logic             Halt
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("lfsr_ext_counter: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  logic [WIDTH-1:0] step_q;
  logic             at_term;

  lfsr_ext_step #(.WIDTH(WIDTH)) u_step (
    .q  (Q),
    .qn (step_q)
  );

  assign at_term = (Q == Term);

  // Carry-out is deliberately unregistered so a cascade behaves as one wide counter.
  assign Next = CNT & at_term & ~Rst & ~Load & ~Halt;

  // Halt is the only mode state; it is released solely by Rst or Load.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Q    <= '0;
      Halt <= 1'b0;
    end else if (Load) begin
      Q    <= D;
      Halt <= 1'b0;
    end else if (!Halt && CNT) begin
      if (at_term) begin
        if (Stop) Halt <= 1'b1;
        else      Q    <= '0;
      end else begin
        Q <= step_q;
      end
    end
  end

endmodule
